// File: rtl/mem_arbiter_2x.sv
// Two-requester round-robin arbiter in front of a single-port 64x32 data memory.
// Each access takes one IDLE arbitration cycle and one ACC cycle that drives the memory.
module mem_arbiter_2x #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic                r_win;
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic                w_winner;
  logic                w_anyReq;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_anyReq = req0 | req1;
    w_winner = 1'b0;
    if (req0 && req1) begin
      w_winner = ~r_last;
    end else if (req1) begin
      w_winner = 1'b1;
    end
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_stateNext = ACC;
      ACC:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    if (r_state == ACC) begin
      gnt0         = ~r_win;
      gnt1         = r_win;
      mem_memwrite = r_we;
      mem_memread  = ~r_we;
    end
  end

  // mem_addr/mem_wd always reflect the latched command so they hold between accesses.
  assign mem_addr = r_addr;
  assign mem_wd   = r_wdata;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (r_state == IDLE && w_anyReq) begin
        r_win   <= w_winner;
        r_we    <= w_winner ? we1 : we0;
        r_addr  <= w_winner ? addr1 : addr0;
        r_wdata <= w_winner ? wdata1 : wdata0;
      end
      if (r_state == ACC) begin
        r_last <= r_win;
        if (!r_we) begin
          if (r_win) begin
            r_rdata1  <= mem_rd;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= mem_rd;
            r_rvalid0 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2x.sv
// Directed bench for mem_arbiter_2x with a behavioural 64x32 memory on the memory port.
// Each scenario task drives inputs and checks outputs on the falling clock edge.
module tb_mem_arbiter_2x;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_memwrite, mem_memread;
  logic [31:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [5:0]  mem_addr;

  logic [31:0] memModel [64];
  logic [31:0] sb [64];
  int          testsRun = 0;
  int          failCount = 0;
  bit          monEn = 1'b0;
  bit          prevGnt = 1'b0;

  mem_arbiter_2x #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_memwrite) memModel[mem_addr] <= mem_wd;
  assign mem_rd = memModel[mem_addr];

  task automatic doReset();
    @(negedge clk); rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic waitGnt(input bit which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4 && !ok; k++) begin
      @(negedge clk);
      if ((which ? gnt1 : gnt0) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    testsRun++; if ({gnt0, gnt1, mem_memwrite, mem_memread, rvalid0, rvalid1} !== 6'b0) begin failCount++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, mem_memwrite, mem_memread, rvalid0, rvalid1}); end
    testsRun++; if (mem_addr !== 6'd0 || mem_wd !== 32'd0) begin failCount++; $display("[TB] FAIL reset_mem: got addr %0d wd %h expected 0/0", mem_addr, mem_wd); end
    testsRun++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1); end
    rst = 1'b0; monEn = 1'b1;
  endtask

  task automatic test_single_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    testsRun++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failCount++; $display("[TB] FAIL wr_gnt: got %b%b expected 10", gnt0, gnt1); end
    testsRun++; if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0) begin failCount++; $display("[TB] FAIL wr_en: got we %b re %b expected 1/0", mem_memwrite, mem_memread); end
    testsRun++; if (mem_addr !== 6'd5 || mem_wd !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL wr_cmd: got %0d/%h expected 5/deadbeef", mem_addr, mem_wd); end
    req0 = 1'b0;
    @(negedge clk);
    testsRun++; if (gnt0 !== 1'b0 || rvalid0 !== 1'b0 || mem_memwrite !== 1'b0) begin failCount++; $display("[TB] FAIL wr_after: got gnt %b rvalid %b we %b expected 0/0/0", gnt0, rvalid0, mem_memwrite); end
    testsRun++; if (mem_addr !== 6'd5) begin failCount++; $display("[TB] FAIL addr_hold: got %0d expected 5", mem_addr); end
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    testsRun++; if (gnt0 !== 1'b1 || mem_memread !== 1'b1 || mem_memwrite !== 1'b0) begin failCount++; $display("[TB] FAIL rd_gnt: got gnt %b re %b we %b expected 1/1/0", gnt0, mem_memread, mem_memwrite); end
    req0 = 1'b0;
    @(negedge clk);
    testsRun++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rd_data: got v %b %h expected 1 deadbeef", rvalid0, rdata0); end
    @(negedge clk);
    testsRun++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rd_hold: got v %b %h expected 0 deadbeef", rvalid0, rdata0); end
  endtask

  task automatic test_tie_after_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd9; wdata1 = 32'h12345678;
    @(negedge clk);
    testsRun++; if (gnt1 !== 1'b1) begin failCount++; $display("[TB] FAIL tie_prewr: got gnt1 %b expected 1", gnt1); end
    req1 = 1'b0;
    @(negedge clk);
    doReset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd9;
    @(negedge clk);
    testsRun++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 6'd5) begin failCount++; $display("[TB] FAIL tie_first: got %b%b addr %0d expected 10 addr 5", gnt0, gnt1, mem_addr); end
    req0 = 1'b0;
    @(negedge clk);
    testsRun++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || gnt1 !== 1'b0) begin failCount++; $display("[TB] FAIL tie_rv0: got v %b %h gnt1 %b expected 1 deadbeef 0", rvalid0, rdata0, gnt1); end
    @(negedge clk);
    testsRun++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_addr !== 6'd9) begin failCount++; $display("[TB] FAIL tie_second: got %b%b addr %0d expected 01 addr 9", gnt0, gnt1, mem_addr); end
    req1 = 1'b0;
    @(negedge clk);
    testsRun++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678 || rvalid0 !== 1'b0) begin failCount++; $display("[TB] FAIL tie_rv1: got v1 %b %h v0 %b expected 1 12345678 0", rvalid1, rdata1, rvalid0); end
  endtask

  task automatic test_contention();
    doReset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      testsRun++;
      if (gnt0 !== (k % 4 == 1) || gnt1 !== (k % 4 == 3)) begin
        failCount++; $display("[TB] FAIL contention_c%0d: got %b%b expected %b%b", k, gnt0, gnt1, (k % 4 == 1), (k % 4 == 3));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_check();
    bit ok;
    logic [5:0] a;
    for (int i = 0; i < 64; i++) begin
      a = 6'(i); sb[i] = $urandom;
      req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = sb[i];
      waitGnt(1'b1, ok);
      testsRun++; if (!ok || mem_memwrite !== 1'b1) begin failCount++; $display("[TB] FAIL fill_wr%0d: got gnt %b we %b expected 1/1", i, ok, mem_memwrite); end
      req1 = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i <= 64; i++) begin
      a = 6'(i);
      req0 = 1'b1; we0 = 1'b0; addr0 = a;
      waitGnt(1'b0, ok);
      req0 = 1'b0;
      @(negedge clk);
      testsRun++; if (!ok || rvalid0 !== 1'b1 || rdata0 !== sb[a]) begin failCount++; $display("[TB] FAIL fill_rd%0d: got gnt %b v %b %h expected 1 1 %h", i, ok, rvalid0, rdata0, sb[a]); end
    end
  endtask

  task automatic test_reset_mid_access();
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd9;
    @(negedge clk);
    testsRun++; if (gnt1 !== 1'b1) begin failCount++; $display("[TB] FAIL mid_gnt1: got %b expected 1", gnt1); end
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    testsRun++; if ({gnt0, gnt1, mem_memwrite, mem_memread, rvalid0, rvalid1} !== 6'b0) begin failCount++; $display("[TB] FAIL mid_ctrl: got %b expected 000000", {gnt0, gnt1, mem_memwrite, mem_memread, rvalid0, rvalid1}); end
    testsRun++; if (mem_addr !== 6'd0 || mem_wd !== 32'd0 || rdata1 !== 32'd0) begin failCount++; $display("[TB] FAIL mid_regs: got %0d %h %h expected 0 0 0", mem_addr, mem_wd, rdata1); end
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd4;
    @(negedge clk);
    testsRun++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failCount++; $display("[TB] FAIL mid_tie: got %b%b expected 10", gnt0, gnt1); end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (monEn) begin
          testsRun++;
          if ((gnt0 & gnt1) || (rvalid0 & rvalid1) || (mem_memwrite & mem_memread) || (prevGnt && (gnt0 | gnt1))) begin
            failCount++; $display("[TB] FAIL invariant: got gnt %b%b rvalid %b%b we/re %b%b prevGnt %b expected exclusive, no back-to-back gnt", gnt0, gnt1, rvalid0, rvalid1, mem_memwrite, mem_memread, prevGnt);
          end
          prevGnt = gnt0 | gnt1;
        end
      end
    join_none
    test_reset();
    test_single_write_read();
    test_tie_after_reset();
    test_contention();
    test_fill_check();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2x.md
MEM_ARBITER_2X -- requirements
Module: mem_arbiter_2x

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, memory word-address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports req0/req1, input, 1 bit each, access request from requester 0/1.
REQ-006 SHALL have ports we0/we1, input, 1 bit each, 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W each, word address.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_W each, write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1 bit each, one-cycle grant/ack pulse.
REQ-010 SHALL have ports rdata0/rdata1, output, DATA_W each, registered read data.
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 bit each, one-cycle read-data-valid pulse.
REQ-012 SHALL have port mem_addr, output, ADDR_W, address to data_mem_64x32 addr.
REQ-013 SHALL have port mem_wd, output, DATA_W, write data to memory wd.
REQ-014 SHALL have port mem_memwrite, output, 1 bit, memory write enable.
REQ-015 SHALL have port mem_memread, output, 1 bit, memory read enable.
REQ-016 SHALL have port mem_rd, input, DATA_W, memory read data (combinational w.r.t. mem_addr).

Function
REQ-017 SHALL implement FSM states IDLE and ACC, plus 1-bit winner register win and 1-bit last-grant pointer last.
REQ-018 In IDLE with req0|req1 sampled high, SHALL latch winner's we/addr/wdata into command register, set win, go to ACC next cycle.
REQ-019 In IDLE with no request, SHALL stay in IDLE.
REQ-020 Arbitration: one requester -> that one wins; both -> winner is the requester != last (round-robin).
REQ-021 ACC SHALL last exactly one cycle, then return to IDLE; last <= win on leaving ACC.
REQ-022 In ACC: mem_addr/mem_wd = latched command; mem_memwrite = latched we; mem_memread = ~latched we; gnt[win] = 1.
REQ-023 Outside ACC: mem_memwrite = 0, mem_memread = 0, gnt0 = gnt1 = 0; mem_addr/mem_wd hold last command.
REQ-024 Read in ACC: rdata[win] <= mem_rd at the edge ending ACC; rvalid[win] = 1 for exactly the following cycle.
REQ-025 Write in ACC: memory commits at the edge ending ACC; no rvalid pulse; rdata unchanged.
REQ-026 rdataX SHALL hold its value until its next read completes.
REQ-027 Latency: req high in IDLE cycle N -> gnt in N+1 -> rvalid/rdata in N+2; peak rate one access per 2 cycles.
REQ-028 Requester SHALL keep req/we/addr/wdata stable until it sees gnt, then drop req the following cycle or be treated as a new request.
REQ-029 Inputs SHALL be ignored while in ACC; a req rising during ACC is arbitrated in the next IDLE cycle.
REQ-030 At most one of gnt0/gnt1, one of rvalid0/rvalid1, and one of mem_memwrite/mem_memread SHALL be high in any cycle.

Reset
REQ-031 With rst high at a rising edge: state <= IDLE, last <= 1 (requester 0 wins first tie), win <= 0, command register <= 0, rdata0/rdata1 <= 0, rvalid0/rvalid1 <= 0.
REQ-032 Outputs after reset: gnt0 = gnt1 = 0, mem_memwrite = mem_memread = 0, mem_addr = 0, mem_wd = 0.
REQ-033 rst SHALL override all transitions; a write driven in ACC at the reset edge commits to memory, but no rvalid follows and last is not updated.

Verification
REQ-034 Single write/read: req0, we0=1, addr0=5, wdata0=0xDEADBEEF -> gnt0 next cycle with mem_memwrite=1, mem_addr=5; then read addr0=5 -> rvalid0 2 cycles after req, rdata0=0xDEADBEEF.
REQ-035 Tie after reset: req0 and req1 both reads -> gnt0 first, gnt1 two cycles later; rvalid1 one cycle after gnt1.
REQ-036 Continuous contention: req0 and req1 held high 20 cycles, re-requesting after each gnt -> grants strictly alternate 0,1,0,1, each requester granted every 4 cycles.
REQ-037 Fill/check: requester 1 writes $random to all 64 addresses, requester 0 reads all 64 -> every rdata0 matches scoreboard, zero mismatches, addr wraps 63->0 without error.
REQ-038 Reset mid-access: assert rst during ACC of a read by requester 1 -> no rvalid1, all outputs at reset values next cycle, next tie granted to requester 0.
REQ-039 Invariant checks every cycle: REQ-030 exclusivity; gnt never high in two consecutive cycles.
